// File: rtl/mem_stage.sv
`default_nettype none
// ============================================================================
// Module   : mem_stage
// Brief    : Memory stage: loads/stores over a req/ready + rvalid handshake,
//            taken-branch redirect and a single registered writeback port.
// Revision : 1.0 - initial release
// ============================================================================
module mem_stage #(
  parameter int XLEN = 64
) (
  input  logic            CLK,
  input  logic            RST,
  input  logic [XLEN-1:0] alu_res_i,
  input  logic            alu_write_back_en_i,
  input  logic [4:0]      rd_i,
  input  logic            load_flag_i,
  input  logic            mem_en_i,
  input  logic [2:0]      funct3_i,
  input  logic [XLEN-1:0] store_data_i,
  input  logic            branch_flag_i,
  input  logic [XLEN-1:0] branch_offset_i,
  input  logic [XLEN-1:0] PC_i,
  output logic            stall_o,
  output logic            dmem_req_o,
  output logic            dmem_we_o,
  output logic [XLEN-1:0] dmem_addr_o,
  output logic [XLEN-1:0] dmem_wdata_o,
  output logic [7:0]      dmem_wstrb_o,
  input  logic            dmem_ready_i,
  input  logic            dmem_rvalid_i,
  input  logic [XLEN-1:0] dmem_rdata_i,
  output logic            wb_en_o,
  output logic [4:0]      wb_rd_o,
  output logic [XLEN-1:0] wb_data_o,
  output logic            redirect_o,
  output logic [XLEN-1:0] redirect_pc_o
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_REQ  = 2'd1,
    S_WAIT = 2'd2
  } state_t;

  state_t          r_state,     w_state_nxt;
  logic            r_req,       w_req_nxt;
  logic            r_we,        w_we_nxt;
  logic [XLEN-1:0] r_addr,      w_addr_nxt;
  logic [XLEN-1:0] r_wdata,     w_wdata_nxt;
  logic [7:0]      r_wstrb,     w_wstrb_nxt;
  logic            r_wb_en,     w_wb_en_nxt;
  logic [4:0]      r_wb_rd,     w_wb_rd_nxt;
  logic [XLEN-1:0] r_wb_data,   w_wb_data_nxt;
  logic            r_redir,     w_redir_nxt;
  logic [XLEN-1:0] r_redir_pc,  w_redir_pc_nxt;
  logic [2:0]      r_off,       w_off_nxt;
  logic [2:0]      r_f3,        w_f3_nxt;
  logic [4:0]      r_rd,        w_rd_nxt;
  logic            r_load,      w_load_nxt;

  logic [7:0]      w_mask;
  logic [XLEN-1:0] w_ld_shift;
  logic [XLEN-1:0] w_ld_data;

  always_comb begin
    w_mask = 8'h01;
    case (funct3_i[1:0])
      2'b00:   w_mask = 8'h01;
      2'b01:   w_mask = 8'h03;
      2'b10:   w_mask = 8'h0F;
      default: w_mask = 8'hFF;
    endcase
  end

  // Bring the addressed byte lane down to bit 0 before size/sign selection.
  assign w_ld_shift = dmem_rdata_i >> {r_off, 3'b000};

  always_comb begin
    w_ld_data = w_ld_shift;
    case (r_f3)
      3'b000:  w_ld_data = {{(XLEN-8){w_ld_shift[7]}},   w_ld_shift[7:0]};
      3'b001:  w_ld_data = {{(XLEN-16){w_ld_shift[15]}}, w_ld_shift[15:0]};
      3'b010:  w_ld_data = {{(XLEN-32){w_ld_shift[31]}}, w_ld_shift[31:0]};
      3'b100:  w_ld_data = {{(XLEN-8){1'b0}},            w_ld_shift[7:0]};
      3'b101:  w_ld_data = {{(XLEN-16){1'b0}},           w_ld_shift[15:0]};
      3'b110:  w_ld_data = {{(XLEN-32){1'b0}},           w_ld_shift[31:0]};
      default: w_ld_data = w_ld_shift;
    endcase
  end

  always_comb begin
    w_state_nxt    = r_state;
    w_req_nxt      = r_req;
    w_we_nxt       = r_we;
    w_addr_nxt     = r_addr;
    w_wdata_nxt    = r_wdata;
    w_wstrb_nxt    = r_wstrb;
    w_wb_en_nxt    = 1'b0;
    w_wb_rd_nxt    = r_wb_rd;
    w_wb_data_nxt  = r_wb_data;
    w_redir_nxt    = 1'b0;
    w_redir_pc_nxt = r_redir_pc;
    w_off_nxt      = r_off;
    w_f3_nxt       = r_f3;
    w_rd_nxt       = r_rd;
    w_load_nxt     = r_load;

    case (r_state)
      S_IDLE: begin
        if (branch_flag_i) begin
          w_redir_nxt    = alu_res_i[0];
          w_redir_pc_nxt = PC_i + branch_offset_i;
        end else if (mem_en_i) begin
          w_off_nxt   = alu_res_i[2:0];
          w_f3_nxt    = funct3_i;
          w_rd_nxt    = rd_i;
          w_load_nxt  = load_flag_i;
          w_req_nxt   = 1'b1;
          w_we_nxt    = !load_flag_i;
          w_addr_nxt  = {alu_res_i[XLEN-1:3], 3'b000};
          // Bytes shifted past the doubleword are simply dropped.
          w_wdata_nxt = store_data_i << {alu_res_i[2:0], 3'b000};
          w_wstrb_nxt = w_mask << alu_res_i[2:0];
          w_state_nxt = S_REQ;
        end else begin
          w_wb_en_nxt   = alu_write_back_en_i && (rd_i != 5'd0);
          w_wb_rd_nxt   = rd_i;
          w_wb_data_nxt = alu_res_i;
        end
      end
      S_REQ: begin
        if (dmem_ready_i) begin
          w_req_nxt   = 1'b0;
          w_state_nxt = r_load ? S_WAIT : S_IDLE;
        end
      end
      S_WAIT: begin
        if (dmem_rvalid_i) begin
          w_wb_en_nxt   = (r_rd != 5'd0);
          w_wb_rd_nxt   = r_rd;
          w_wb_data_nxt = w_ld_data;
          w_state_nxt   = S_IDLE;
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      r_state    <= S_IDLE;
      r_req      <= 1'b0;
      r_we       <= 1'b0;
      r_addr     <= '0;
      r_wdata    <= '0;
      r_wstrb    <= '0;
      r_wb_en    <= 1'b0;
      r_wb_rd    <= '0;
      r_wb_data  <= '0;
      r_redir    <= 1'b0;
      r_redir_pc <= '0;
      r_off      <= '0;
      r_f3       <= '0;
      r_rd       <= '0;
      r_load     <= 1'b0;
    end else begin
      r_state    <= w_state_nxt;
      r_req      <= w_req_nxt;
      r_we       <= w_we_nxt;
      r_addr     <= w_addr_nxt;
      r_wdata    <= w_wdata_nxt;
      r_wstrb    <= w_wstrb_nxt;
      r_wb_en    <= w_wb_en_nxt;
      r_wb_rd    <= w_wb_rd_nxt;
      r_wb_data  <= w_wb_data_nxt;
      r_redir    <= w_redir_nxt;
      r_redir_pc <= w_redir_pc_nxt;
      r_off      <= w_off_nxt;
      r_f3       <= w_f3_nxt;
      r_rd       <= w_rd_nxt;
      r_load     <= w_load_nxt;
    end
  end

  assign stall_o       = (r_state != S_IDLE);
  assign dmem_req_o    = r_req;
  assign dmem_we_o     = r_we;
  assign dmem_addr_o   = r_addr;
  assign dmem_wdata_o  = r_wdata;
  assign dmem_wstrb_o  = r_wstrb;
  assign wb_en_o       = r_wb_en;
  assign wb_rd_o       = r_wb_rd;
  assign wb_data_o     = r_wb_data;
  assign redirect_o    = r_redir;
  assign redirect_pc_o = r_redir_pc;

endmodule
`default_nettype wire

// File: doc/mem_stage.md
Name: mem_stage

Overview:
- Consumer end of the execute-stage output interface. Takes the registered execute results: result, writeback enable, rd, load and memory-enable flags, branch flag, offset and PC.
- Performs loads and stores over a req/ready plus rvalid data-memory handshake and resolves taken branches into a PC redirect.
- Presents a single registered writeback port to the register file and a stall back to the execute stage.

Parameters:
- XLEN, 64, datapath and address width (fixed at 64; byte logic assumes 8 lanes).

Ports:
- CLK  in  1  clock, rising edge
- RST  in  1  synchronous reset, active-high
- alu_res_i  in  64  execute result; effective address for memory ops; bit 0 is the branch condition
- alu_write_back_en_i  in  1  execute writeback request
- rd_i  in  5  destination register
- load_flag_i  in  1  1 = load, 0 = store (valid when mem_en_i)
- mem_en_i  in  1  memory operation present
- funct3_i  in  3  access size/sign
- store_data_i  in  64  rs2 value for stores
- branch_flag_i  in  1  instruction is a conditional branch
- branch_offset_i  in  64  branch immediate
- PC_i  in  64  instruction PC
- stall_o  out  1  upstream must hold all inputs stable while high (combinational: state != IDLE)
- dmem_req_o  out  1  memory request valid
- dmem_we_o  out  1  1 = write
- dmem_addr_o  out  64  doubleword-aligned address {addr[63:3],3'b0}
- dmem_wdata_o  out  64  lane-aligned store data
- dmem_wstrb_o  out  8  byte strobes
- dmem_ready_i  in  1  request accepted this cycle
- dmem_rvalid_i  in  1  read data valid
- dmem_rdata_i  in  64  aligned read doubleword
- wb_en_o  out  1  register-file write
- wb_rd_o  out  5  write register
- wb_data_o  out  64  write data
- redirect_o  out  1  one-cycle taken-branch pulse
- redirect_pc_o  out  64  branch target

Behaviour:
- Reset: state IDLE. All registered outputs 0. Any outstanding request is abandoned. dmem_rvalid_i is ignored outside WAIT.
- FSM states: IDLE, REQ, WAIT.
- IDLE, branch_flag_i=1:
  - redirect_o<=alu_res_i[0]; redirect_pc_o<=PC_i+branch_offset_i (mod 2^64).
  - wb_en_o<=0. mem_en_i is ignored.
- IDLE, mem_en_i=1:
  - Latch addr, funct3, rd, load flag and store data.
  - Drive dmem_req_o<=1, dmem_we_o<=!load_flag_i, plus addr, wdata and wstrb. Go to REQ. wb_en_o<=0.
- IDLE, other:
  - wb_en_o<=alu_write_back_en_i && rd_i!=0; wb_rd_o<=rd_i; wb_data_o<=alu_res_i. Latency 1 cycle.
- REQ:
  - Request outputs held stable until dmem_ready_i.
  - On ready: dmem_req_o<=0. A store goes to IDLE. A load goes to WAIT.
- WAIT:
  - On dmem_rvalid_i: wb_en_o<=(rd!=0), wb_rd_o<=rd, wb_data_o<=extracted data; go to IDLE.
  - rvalid is never sampled in the same cycle as ready.
- redirect_o and wb_en_o are single-cycle pulses per instruction and are 0 in REQ and WAIT.
- Store encoding (funct3 000/001/010/011 = B/H/W/D):
  - Base mask 0x01/0x03/0x0F/0xFF; wstrb = (mask << addr[2:0]) truncated to 8 bits.
  - wdata = store_data << (8*addr[2:0]), truncated to 64 bits.
  - Misaligned bytes past the doubleword are dropped; no exception is raised.
- Load extraction:
  - d = dmem_rdata_i >> (8*addr[2:0]).
  - 000 LB sign-extends d[7:0]. 001 LH sign-extends d[15:0]. 010 LW sign-extends d[31:0]. 011 LD takes d.
  - 100 LBU, 101 LHU, 110 LWU zero-extend. 111 returns d.
- Instruction held at the inputs during REQ/WAIT is consumed in the first IDLE cycle after completion. No instruction is lost or duplicated.
- RST asserted in REQ/WAIT: return to IDLE next edge with dmem_req_o=0. A late rvalid causes no writeback.

Test Plan:
- ADD result 0x5, rd=3, wb_en=1 at IDLE -> next cycle wb_en_o=1, wb_rd_o=3, wb_data_o=0x5. Same with rd=0 -> wb_en_o=0.
- Branch PC=0x1000, offset=0xFFFF_FFFF_FFFF_FFF0, res=1 -> redirect_o pulse, redirect_pc_o=0xFF0. With res=0 -> no pulse.
- SB addr=0x2003, data=0xAB:
  - ready held low 3 cycles -> req/addr 0x2000/wstrb 0x08/wdata 0xAB000000 held stable, stall_o=1.
  - ready=1 -> IDLE next, no writeback.
- LB addr=0x10 offset 1, rdata=0x0000_0000_0000_8000, rd=5, rvalid 2 cycles after ready:
  - wb_data_o=0xFFFF_FFFF_FFFF_FF80.
  - LBU on the same data -> 0x80. LW on offset 4 with rdata[63:32]=0x8000_0001 -> 0xFFFF_FFFF_8000_0001.
- Load immediately followed by ADD rd=6:
  - ADD held during stall and written back exactly once, in the cycle after the load's writeback.
- RST pulsed while in WAIT, then rvalid arrives -> dmem_req_o=0, no wb_en_o, state IDLE, all outputs 0.
